// File: rtl/qreg_param.sv
// Parametrised Booth multiplier Q register with appended Qm1 bit, shift counter and recode outputs.
// Optional build macro QREG_RADIX4_EN selects two-bit (radix-4) shift steps.
module qreg_param #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       ctrl,
    input  logic [1:0]       si,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             qm1,
    output logic [1:0]       booth_op,
    output logic [2:0]       booth_grp,
    output logic             so,
    output logic [CW-1:0]    shift_cnt,
    output logic             done,
    output logic             ovf
);

    localparam logic [1:0] CTRL_LOAD  = 2'b00;
    localparam logic [1:0] CTRL_CLEAR = 2'b01;
    localparam logic [1:0] CTRL_SHIFT = 2'b10;
    localparam logic [1:0] CTRL_HOLD  = 2'b11;

`ifdef QREG_RADIX4_EN
    localparam int STEP = 2;

    generate
        if ((WIDTH % 2) != 0) begin : g_width_odd
            $error("qreg_param: WIDTH must be even when QREG_RADIX4_EN is defined");
        end
    endgenerate
`else
    localparam int STEP = 1;

    // Radix-2 shifts only consume si[0].
    logic unused_si;
    assign unused_si = si[1];
`endif

    generate
        if (WIDTH < 2) begin : g_width_small
            $error("qreg_param: WIDTH must be at least 2");
        end
    endgenerate

    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_STEP = CW'(STEP);

    logic [WIDTH-1:0] q_q, q_d;
    logic             qm1_q, qm1_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             full;

    assign full = (cnt_q == CNT_FULL);

    always_comb begin
        q_d   = q_q;
        qm1_d = qm1_q;
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unique case (ctrl)
            CTRL_LOAD: begin
                q_d   = d;
                qm1_d = 1'b0;
                cnt_d = '0;
            end
            CTRL_CLEAR: begin
                q_d   = '0;
                qm1_d = 1'b0;
                cnt_d = '0;
            end
            CTRL_SHIFT: begin
                // Once the counter is full the shift is refused and flagged instead.
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    q_d   = q_q >> STEP;
                    qm1_d = q_q[STEP-1];
                    cnt_d = cnt_q + CNT_STEP;
`ifdef QREG_RADIX4_EN
                    q_d[WIDTH-1 -: 2] = si;
`else
                    q_d[WIDTH-1] = si[0];
`endif
                end
            end
            CTRL_HOLD: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_q   <= '0;
            qm1_q <= 1'b0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            qm1_q <= qm1_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign q         = q_q;
    assign qm1       = qm1_q;
    assign booth_op  = {q_q[0], qm1_q};
    assign booth_grp = {q_q[1], q_q[0], qm1_q};
    assign so        = q_q[0];
    assign shift_cnt = cnt_q;
    assign done      = full;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_qreg_param.sv
// Directed bench for qreg_param at WIDTH=8; radix-4 steps are used when QREG_RADIX4_EN is defined.
module tb_qreg_param;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clock = 1'b0;
    logic             reset;
    logic [1:0]       ctrl;
    logic [1:0]       si;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             qm1;
    logic [1:0]       booth_op;
    logic [2:0]       booth_grp;
    logic             so;
    logic [CW-1:0]    shift_cnt;
    logic             done;
    logic             ovf;

    int vectors     = 0;
    int miscompares = 0;

    qreg_param #(.WIDTH(WIDTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .ctrl     (ctrl),
        .si       (si),
        .d        (d),
        .q        (q),
        .qm1      (qm1),
        .booth_op (booth_op),
        .booth_grp(booth_grp),
        .so       (so),
        .shift_cnt(shift_cnt),
        .done     (done),
        .ovf      (ovf)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rst, input logic [1:0] c, input logic [1:0] s, input logic [7:0] dv);
        reset = rst;
        ctrl  = c;
        si    = s;
        d     = dv;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        ctrl  = 2'b11;
        si    = 2'b00;
        d     = 8'h00;

        // Reset wins over a concurrent Load.
        cyc(1'b1, 2'b00, 2'b00, 8'hFF);
        cyc(1'b1, 2'b00, 2'b00, 8'hFF);
        chk("rst_q", q, 8'h00);
        chk("rst_qm1", qm1, 1'b0);
        chk("rst_cnt", shift_cnt, 0);
        chk("rst_done", done, 1'b0);
        chk("rst_ovf", ovf, 1'b0);

        // Load then Hold with different d on the bus.
        cyc(1'b0, 2'b00, 2'b00, 8'hA5);
        chk("load_q", q, 8'hA5);
        chk("load_op", booth_op, 2'b10);
        chk("load_grp", booth_grp, 3'b010);
        cyc(1'b0, 2'b11, 2'b11, 8'hFF);
        cyc(1'b0, 2'b11, 2'b11, 8'hFF);
        chk("hold_q", q, 8'hA5);
        chk("hold_qm1", qm1, 1'b0);
        chk("hold_op", booth_op, 2'b10);
        chk("hold_grp", booth_grp, 3'b010);
        chk("hold_so", so, 1'b1);

`ifndef QREG_RADIX4_EN
        cyc(1'b0, 2'b10, 2'b01, 8'h00);
        chk("sh1_q", q, 8'hD2);
        chk("sh1_qm1", qm1, 1'b1);
        chk("sh1_cnt", shift_cnt, 1);
        chk("sh1_grp", booth_grp, 3'b101);
        chk("sh1_done", done, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 2'b10, 2'b10, 8'h00);
        chk("sh7_cnt", shift_cnt, 7);
        chk("sh7_done", done, 1'b0);
        cyc(1'b0, 2'b10, 2'b10, 8'h00);
        chk("sh8_q", q, 8'h01);
        chk("sh8_qm1", qm1, 1'b1);
        chk("sh8_cnt", shift_cnt, 8);
        chk("sh8_done", done, 1'b1);
        chk("sh8_ovf", ovf, 1'b0);

        // Rejected shifts.
        cyc(1'b0, 2'b10, 2'b01, 8'h00);
        chk("rej_q", q, 8'h01);
        chk("rej_qm1", qm1, 1'b1);
        chk("rej_cnt", shift_cnt, 8);
        chk("rej_ovf", ovf, 1'b1);
        cyc(1'b0, 2'b11, 2'b00, 8'h00);
        chk("rej_ovf_pulse", ovf, 1'b0);
        cyc(1'b0, 2'b10, 2'b00, 8'h00);
        cyc(1'b0, 2'b10, 2'b00, 8'h00);
        chk("rej2_ovf", ovf, 1'b1);
        chk("rej2_cnt", shift_cnt, 8);
        cyc(1'b0, 2'b00, 2'b00, 8'h3C);
        chk("reload_q", q, 8'h3C);
        chk("reload_done", done, 1'b0);
        chk("reload_cnt", shift_cnt, 0);
        chk("reload_ovf", ovf, 1'b0);

        // Abort mid-sequence with reset, then with Clear.
        cyc(1'b0, 2'b00, 2'b00, 8'hA5);
        for (int i = 0; i < 3; i++) cyc(1'b0, 2'b10, 2'b00, 8'h00);
        chk("mid_q", q, 8'h14);
        chk("mid_qm1", qm1, 1'b1);
        chk("mid_cnt", shift_cnt, 3);
        cyc(1'b1, 2'b10, 2'b01, 8'h00);
        chk("abort_rst_q", q, 8'h00);
        chk("abort_rst_qm1", qm1, 1'b0);
        chk("abort_rst_cnt", shift_cnt, 0);
        cyc(1'b0, 2'b00, 2'b00, 8'hA5);
        for (int i = 0; i < 3; i++) cyc(1'b0, 2'b10, 2'b00, 8'h00);
        chk("mid2_q", q, 8'h14);
        cyc(1'b0, 2'b01, 2'b01, 8'hFF);
        chk("abort_clr_q", q, 8'h00);
        chk("abort_clr_qm1", qm1, 1'b0);
        chk("abort_clr_cnt", shift_cnt, 0);
        chk("abort_clr_ovf", ovf, 1'b0);
`else
        cyc(1'b0, 2'b10, 2'b11, 8'h00);
        chk("r4_sh1_q", q, 8'hE9);
        chk("r4_sh1_qm1", qm1, 1'b0);
        chk("r4_sh1_cnt", shift_cnt, 2);
        chk("r4_sh1_done", done, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b0, 2'b10, 2'b00, 8'h00);
        chk("r4_sh3_cnt", shift_cnt, 6);
        chk("r4_sh3_done", done, 1'b0);
        cyc(1'b0, 2'b10, 2'b00, 8'h00);
        chk("r4_sh4_q", q, 8'h03);
        chk("r4_sh4_qm1", qm1, 1'b1);
        chk("r4_sh4_cnt", shift_cnt, 8);
        chk("r4_sh4_done", done, 1'b1);
        cyc(1'b0, 2'b10, 2'b11, 8'h00);
        chk("r4_rej_q", q, 8'h03);
        chk("r4_rej_cnt", shift_cnt, 8);
        chk("r4_rej_ovf", ovf, 1'b1);
        cyc(1'b0, 2'b11, 2'b00, 8'h00);
        chk("r4_rej_pulse", ovf, 1'b0);
        cyc(1'b0, 2'b01, 2'b00, 8'h00);
        chk("r4_clr_q", q, 8'h00);
        chk("r4_clr_cnt", shift_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
